// File: rtl/mips32_pkg.sv
// Shared MIPS32 R-type definitions: instruction field positions, funct and ALU
// codes, the issuer state encoding, and the combinational R-type decoder.
package mips32_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_COMMIT
  } issuer_state_t;

  typedef struct packed {
    logic       legal;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [3:0] func;
  } decoded_t;

  // shamt is deliberately ignored; only opcode and funct decide legality.
  function automatic decoded_t decode_rtype(input logic [31:0] word);
    decoded_t d;
    d.rs    = word[RS_HI:RS_LO];
    d.rt    = word[RT_HI:RT_LO];
    d.rd    = word[RD_HI:RD_LO];
    d.legal = (word[OPCODE_HI:OPCODE_LO] == 6'd0);
    d.func  = ALU_AND;
    case (word[FUNCT_HI:FUNCT_LO])
      FUNCT_ADD, FUNCT_ADDU: d.func = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: d.func = ALU_SUB;
      FUNCT_AND:             d.func = ALU_AND;
      FUNCT_OR:              d.func = ALU_OR;
      FUNCT_NOR:             d.func = ALU_NOR;
      FUNCT_SLT:             d.func = ALU_SLT;
      default:               d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small power-of-two instruction FIFO with occupancy counter and full/empty
// flags derived only from registered state.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int OCC_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rtype_issuer.sv
// Buffers R-type instruction words and sequences the register-file/ALU
// datapath through DECODE -> EXEC -> COMMIT, counting retirements.
module rtype_issuer
  import mips32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [4:0]       read_address1,
  output logic [4:0]       read_address2,
  output logic [4:0]       write_address,
  output logic [3:0]       func,
  output logic             write_enable,
  input  logic             isZero,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] zero_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  issuer_state_t state;
  issuer_state_t state_next;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  decoded_t      dec;
  logic          take_legal;
  logic          take_illegal;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (instr_valid && !fifo_full),
    .pop   (fifo_pop),
    .wdata (instr),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_ready  = !fifo_full;
  assign busy         = !fifo_empty || (state != ST_IDLE);
  assign dec          = decode_rtype(fifo_head);
  assign take_legal   = (state == ST_DECODE) && !fifo_empty && dec.legal;
  assign take_illegal = (state == ST_DECODE) && !fifo_empty && !dec.legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // A rejected word chains straight into another DECODE only if something
  // besides the word being popped is already waiting.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_next = ST_DECODE;
      ST_DECODE: begin
        fifo_pop = !fifo_empty;
        if (fifo_empty)                state_next = ST_IDLE;
        else if (dec.legal)            state_next = ST_EXEC;
        else if (fifo_count > CW'(1))  state_next = ST_DECODE;
        else                           state_next = ST_IDLE;
      end
      ST_EXEC:   state_next = ST_COMMIT;
      ST_COMMIT: state_next = fifo_empty ? ST_IDLE : ST_DECODE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath controls are registered so the ALU sees stable operands for all
  // of EXEC; the write strobe is armed from EXEC and so lands in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_address1 <= '0;
      read_address2 <= '0;
      write_address <= '0;
      func          <= '0;
      write_enable  <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
      zero_count    <= '0;
    end else begin
      illegal      <= take_illegal;
      write_enable <= (state == ST_EXEC) && (write_address != 5'd0);
      if (take_legal) begin
        read_address1 <= dec.rs;
        read_address2 <= dec.rt;
        write_address <= dec.rd;
        func          <= dec.func;
      end
      if (state == ST_COMMIT) begin
        if (retired_count != '1)          retired_count <= retired_count + 1'b1;
        if (isZero && zero_count != '1)   zero_count    <= zero_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/rtype_issuer.md
# rtype_issuer

Instruction-side driver for the MIPS32 register-file/ALU datapath. Accepts 32-bit R-type MIPS instruction words over a valid/ready handshake and buffers them in a small FIFO. Decodes each word and sequences the datapath control inputs: two read addresses, one write address, the 4-bit ALU function and write enable. Retired-instruction and zero-result counts are returned to the test harness.

## Interface
Parameters:
- DEPTH, 2: instruction FIFO entries (power of two, ≥2)
- CNT_W, 16: width of the retired and zero-result counters

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  MIPS instruction word
- instr_valid  in  1  instr holds a valid word
- instr_ready  out  1  FIFO can accept; transfer when valid && ready at clk edge
- read_address1  out  5  rs field to datapath
- read_address2  out  5  rt field to datapath
- write_address  out  5  rd field to datapath
- func  out  4  ALU control code
- write_enable  out  1  datapath register-file write strobe
- isZero  in  1  ALU zero flag from datapath
- illegal  out  1  one-cycle pulse, word rejected
- busy  out  1  FIFO non-empty or FSM not IDLE
- retired_count  out  CNT_W  committed instructions, saturating
- zero_count  out  CNT_W  commits with isZero=1, saturating

## Operation
- Legal word: opcode [31:26]=0 and funct [5:0] in {0x20 add, 0x21 addu → 4'h2; 0x22 sub, 0x23 subu → 4'h6; 0x24 and → 4'h0; 0x25 or → 4'h1; 0x27 nor → 4'hC; 0x2A slt → 4'h7}. shamt is ignored. Every other word is illegal.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to DECODE.
  - DECODE: pop the FIFO into the instruction register. Legal → EXEC. Illegal → pulse illegal and go to IDLE, or to DECODE if more entries are queued. An illegal word makes no datapath write and no count change.
  - EXEC: drive rs/rt/rd/func with write_enable=0 so ALU operands settle. Next state is COMMIT.
  - COMMIT:
    - Drive write_enable=1 unless rd=0. A write to $0 is suppressed but still retires.
    - Sample isZero.
    - Increment retired_count, and increment zero_count if isZero=1.
    - Next state is DECODE if the FIFO is non-empty, else IDLE.
- Address and func outputs are registered. They hold their last values in IDLE and DECODE.
- FIFO:
  - instr_ready = !full, computed from registered occupancy only.
  - A push while full cannot happen.
  - A push and a pop in the same cycle are both honoured.
  - Read and write pointers wrap modulo DEPTH.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values: all addresses 0, func 0, write_enable 0, illegal 0, busy 0, both counters 0, FIFO empty, instr_ready 1, state IDLE.
- rst asserted mid-instruction: write_enable drops immediately (asynchronously) and the FIFO is flushed.
- Single instruction accepted at edge N into an empty FIFO:
  - Cycle N+1: IDLE.
  - Cycle N+2: DECODE.
  - Cycle N+3: EXEC, with addresses/func valid.
  - Cycle N+4: COMMIT, write_enable=1, register written at the end-of-cycle edge.
  - Counters update at that edge.
- Back-to-back throughput: one instruction per 3 cycles (DECODE→EXEC→COMMIT).
- illegal is high for exactly the cycle after the DECODE that rejected the word.

## Structure
- Shared package mips32_pkg holds:
  - funct constants
  - ALU func codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR)
  - issuer state enum
  - field-slice constants for opcode/rs/rt/rd/funct
- One sub-module: instr_fifo (parameterised DEPTH, 32-bit, with full/empty flags).
- Decode is a combinational function in the package.

## Test plan
- Reset, then push 0x01095020 (add $10,$8,$9): 3 cycles after DECODE, rs=8, rt=9, rd=10, func=4'h2, write_enable for exactly 1 cycle; retired_count=1.
- With DEPTH=2, push 0x00221822 (sub $3,$1,$2) three times back-to-back: instr_ready drops while full; all three retire with func=4'h6, commits 3 cycles apart; retired_count=3.
- Push 0x21080001 (addi, illegal): illegal pulses once, write_enable never asserted, counters unchanged; next queued legal word still executes.
- Push 0x00220020 (add $0,$1,$2) with isZero=1: write_enable stays 0, retired_count=1, zero_count=1.
- Assert rst during EXEC with 2 words queued: outputs return to reset values immediately, no write occurs, busy=0.
- Preload retired_count near all-ones (CNT_W=4, 17 instructions): count stops at 4'hF.
